// File: rtl/ps2_keyboard_decoder.sv
// ps2_keyboard_decoder: PS/2 Set 2 receiver and make/break decoder producing ASCII key strobes
module ps2_keyboard_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_key,
  output logic [7:0] scancode,
  output logic       valid,
  output logic       shift_on,
  output logic       caps_on,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic [9:0]             sr_q;
  logic [3:0]             bit_cnt_q;
  logic [TW-1:0]          tmo_q;
  logic [7:0]             byte_q;
  logic                   byte_stb_q, err_q;
  state_t                 state_q, state_d;
  logic [7:0]             ascii_q, ascii_d, scan_q, scan_d, lut;
  logic                   valid_q, valid_d, lshift_q, lshift_d, rshift_q, rshift_d;
  logic                   caps_held_q, caps_held_d, caps_q, caps_d;
  logic                   fall, last, good, tmo_hit, make, brk, letter, key_evt;
  logic [10:0]            frame;
  assign fall      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign frame     = {dat_sync_q[SYNC_STAGES-1], sr_q};
  assign good      = ~frame[0] & frame[10] & ^frame[9:1];
  assign last      = fall & (bit_cnt_q == 4'd10);
  assign tmo_hit   = ~fall & (bit_cnt_q != 4'd0) & (tmo_q == TW'(TIMEOUT_CYCLES));
  assign ascii_key = ascii_q;
  assign scancode  = scan_q;
  assign valid     = valid_q;
  assign shift_on  = lshift_q | rshift_q;
  assign caps_on   = caps_q;
  assign frame_err = err_q;
  // Synchronise the raw PS/2 pins and keep the previous synced clock for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end
  // Shift in frame bits on falling edges, validate on the 11th bit and abandon stalled frames
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      tmo_q      <= '0;
      byte_q     <= '0;
      byte_stb_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      byte_stb_q <= last & good;
      err_q      <= (last & ~good) | tmo_hit;
      if (last & good) byte_q <= frame[8:1];
      if (fall) begin
        sr_q      <= frame[10:1];
        bit_cnt_q <= last ? 4'd0 : bit_cnt_q + 4'd1;
        tmo_q     <= '0;
      end else if (tmo_hit) begin
        bit_cnt_q <= 4'd0;
        tmo_q     <= '0;
      end else begin
        tmo_q <= (bit_cnt_q == 4'd0) ? '0 : tmo_q + 1'b1;
      end
    end
  end
  // Scancode to unshifted ASCII; zero marks an unmapped key
  always_comb begin
    lut = 8'h00;
    case (byte_q)
      8'h1C: lut = "a";
      8'h32: lut = "b";
      8'h21: lut = "c";
      8'h23: lut = "d";
      8'h24: lut = "e";
      8'h2B: lut = "f";
      8'h34: lut = "g";
      8'h33: lut = "h";
      8'h43: lut = "i";
      8'h3B: lut = "j";
      8'h42: lut = "k";
      8'h4B: lut = "l";
      8'h3A: lut = "m";
      8'h31: lut = "n";
      8'h44: lut = "o";
      8'h4D: lut = "p";
      8'h15: lut = "q";
      8'h2D: lut = "r";
      8'h1B: lut = "s";
      8'h2C: lut = "t";
      8'h3C: lut = "u";
      8'h2A: lut = "v";
      8'h1D: lut = "w";
      8'h22: lut = "x";
      8'h35: lut = "y";
      8'h1A: lut = "z";
      8'h45: lut = "0";
      8'h16: lut = "1";
      8'h1E: lut = "2";
      8'h26: lut = "3";
      8'h25: lut = "4";
      8'h2E: lut = "5";
      8'h36: lut = "6";
      8'h3D: lut = "7";
      8'h3E: lut = "8";
      8'h46: lut = "9";
      8'h29: lut = 8'h20;
      8'h5A: lut = 8'h0D;
      8'h66: lut = 8'h08;
      default: lut = 8'h00;
    endcase
  end
  // Prefix FSM and modifier/key next-state, evaluated only on a byte strobe
  always_comb begin
    make        = byte_stb_q & (state_q == IDLE) & (byte_q != 8'hF0) & (byte_q != 8'hE0);
    brk         = byte_stb_q & (state_q == BRK);
    key_evt     = make | brk;
    letter      = (lut >= 8'h61) & (lut <= 8'h7A);
    state_d     = state_q;
    if (byte_stb_q)
      state_d = (state_q == IDLE) ? ((byte_q == 8'hF0) ? BRK : (byte_q == 8'hE0) ? EXT : IDLE)
              : (state_q == EXT && byte_q == 8'hF0) ? EXT_BRK : IDLE;
    valid_d     = make & (lut != 8'h00);
    ascii_d     = valid_d ? ((letter & (shift_on ^ caps_on)) ? lut - 8'h20 : lut) : ascii_q;
    scan_d      = valid_d ? byte_q : scan_q;
    lshift_d    = (key_evt & (byte_q == 8'h12)) ? make : lshift_q;
    rshift_d    = (key_evt & (byte_q == 8'h59)) ? make : rshift_q;
    caps_held_d = (key_evt & (byte_q == 8'h58)) ? make : caps_held_q;
    caps_d      = (make & (byte_q == 8'h58) & ~caps_held_q) ? ~caps_q : caps_q;
  end
  // Register FSM state, modifiers and the key outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ascii_q     <= '0;
      scan_q      <= '0;
      valid_q     <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_held_q <= 1'b0;
      caps_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ascii_q     <= ascii_d;
      scan_q      <= scan_d;
      valid_q     <= valid_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_held_q <= caps_held_d;
      caps_q      <= caps_d;
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// tb_ps2_keyboard_decoder: randomized PS/2 keystroke stimulus checked against a keyboard model
module tb_ps2_keyboard_decoder;
  localparam int TO = 300;
  localparam int SS = 2;
  logic clk = 1'b0, rstn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] ascii_key, scancode;
  logic valid, shift_on, caps_on, frame_err;
  int checks = 0, passed = 0, err_cnt = 0, cyc = 0, last_fall = 0;
  typedef struct {logic [7:0] a; logic [7:0] s;} key_t;
  key_t exp_q[$];
  key_t e;
  logic m_ls, m_rs, m_ch, m_caps, m_ext, m_brk;
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] others [10] = '{8'h12, 8'h59, 8'h58, 8'h29, 8'h5A, 8'h66, 8'h05, 8'h75, 8'h76, 8'h0D};

  ps2_keyboard_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ascii_key(ascii_key), .scancode(scancode), .valid(valid),
    .shift_on(shift_on), .caps_on(caps_on), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every valid pulse must match the next expected key, two cycles after stop-bit sampling
  // (stop fall driven at cycle c -> SS sync cycles -> edge-detect sample -> strobe -> valid)
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (valid) begin
      checks++;
      if (exp_q.size() == 0)
        $display("FAIL unexpected_valid: got ascii=%h scancode=%h, required no pulse", ascii_key, scancode);
      else begin
        e = exp_q.pop_front();
        if ({ascii_key, scancode} !== {e.a, e.s} || cyc != last_fall + SS + 2)
          $display("FAIL key_pulse: got ascii=%h scancode=%h cycle=%0d, required ascii=%h scancode=%h cycle=%0d",
                   ascii_key, scancode, cyc, e.a, e.s, last_fall + SS + 2);
        else passed++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic push(input logic [7:0] a, input logic [7:0] s);
    key_t k;
    k.a = a;
    k.s = s;
    exp_q.push_back(k);
  endtask

  task automatic model_reset();
    {m_ls, m_rs, m_ch, m_caps, m_ext, m_brk} = '0;
    exp_q.delete();
  endtask

  task automatic model_key(input logic [7:0] b, input logic mk);
    if (b == 8'h12) m_ls = mk;
    else if (b == 8'h59) m_rs = mk;
    else if (b == 8'h58) begin
      if (mk && !m_ch) m_caps = ~m_caps;
      m_ch = mk;
    end else if (mk) begin
      for (int i = 0; i < 26; i++)
        if (letters[i] == b) push(((m_ls | m_rs) ^ m_caps) ? 8'h41 + i[7:0] : 8'h61 + i[7:0], b);
      for (int i = 0; i < 10; i++)
        if (digits[i] == b) push(8'h30 + i[7:0], b);
      if (b == 8'h29) push(8'h20, b);
      if (b == 8'h5A) push(8'h0D, b);
      if (b == 8'h66) push(8'h08, b);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0 && !m_ext && !m_brk) m_ext = 1'b1;
    else if (b == 8'hF0 && !m_brk) m_brk = 1'b1;
    else begin
      if (!m_ext) model_key(b, !m_brk);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic d);
    ps2_data = d;
    repeat (6) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (12) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  task automatic send(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) f[9] = ~f[9];
    if (kind == 2) f[10] = 1'b0;
    if (kind == 3) f[0] = 1'b1;
    if (kind == 0) model_byte(b);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++;
    if ({ascii_key, scancode, valid, shift_on, caps_on, frame_err} !== 20'h0)
      $display("FAIL reset_outputs: got %h, required 0", {ascii_key, scancode, valid, shift_on, caps_on, frame_err});
    else passed++;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_letter();
    send(8'h1C, 0);
    send(8'hF0, 0);
    send(8'h1C, 0);
    checks++;
    if ({ascii_key, scancode} !== 16'h611C)
      $display("FAIL letter_hold: got %h, required 611c", {ascii_key, scancode});
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL letter_pending: %0d pulses missing, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_shift();
    send(8'h12, 0);
    checks++;
    if (shift_on !== 1'b1) $display("FAIL shift_held: got %b, required 1", shift_on);
    else passed++;
    send(8'h1C, 0);
    send(8'hF0, 0);
    send(8'h12, 0);
    checks++;
    if (shift_on !== 1'b0) $display("FAIL shift_released: got %b, required 0", shift_on);
    else passed++;
    send(8'h1C, 0);
    send(8'h59, 0);
    send(8'h35, 0);
    send(8'hF0, 0);
    send(8'h59, 0);
    checks++;
    if (exp_q.size() != 0) $display("FAIL shift_pending: %0d pulses missing, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_caps();
    send(8'h58, 0);
    checks++;
    if (caps_on !== 1'b1) $display("FAIL caps_first: got %b, required 1", caps_on);
    else passed++;
    send(8'h58, 0);
    send(8'hF0, 0);
    send(8'h58, 0);
    checks++;
    if (caps_on !== 1'b1) $display("FAIL caps_repeat: got %b, required 1", caps_on);
    else passed++;
    send(8'h1C, 0);
    send(8'h12, 0);
    send(8'h1C, 0);
    send(8'hF0, 0);
    send(8'h12, 0);
    send(8'h58, 0);
    send(8'hF0, 0);
    send(8'h58, 0);
    checks++;
    if (caps_on !== 1'b0) $display("FAIL caps_off: got %b, required 0", caps_on);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL caps_pending: %0d pulses missing, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_misc_keys();
    send(8'h16, 0);
    send(8'h29, 0);
    send(8'h5A, 0);
    send(8'h66, 0);
    send(8'h05, 0);
    checks++;
    if ({ascii_key, scancode} !== 16'h0866)
      $display("FAIL unmapped_hold: got %h, required 0866", {ascii_key, scancode});
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL misc_pending: %0d pulses missing, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_extended();
    send(8'hE0, 0);
    send(8'h75, 0);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h75, 0);
    send(8'h1C, 0);
    checks++;
    if (exp_q.size() != 0) $display("FAIL extended_pending: %0d pulses missing, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_errors();
    int e0;
    logic [10:0] f;
    e0 = err_cnt;
    send(8'h1C, 1);
    checks++;
    if (err_cnt != e0 + 1) $display("FAIL parity_err: got %0d pulses, required %0d", err_cnt - e0, 1);
    else passed++;
    send(8'h1C, 2);
    send(8'h32, 3);
    checks++;
    if (err_cnt != e0 + 3) $display("FAIL start_stop_err: got %0d pulses, required %0d", err_cnt - e0, 3);
    else passed++;
    f = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 4; i++) ps2_bit(f[i]);
    repeat (TO + 50) @(negedge clk);
    checks++;
    if (err_cnt != e0 + 4) $display("FAIL timeout_err: got %0d pulses, required %0d", err_cnt - e0, 4);
    else passed++;
    repeat (2 * TO) @(negedge clk);
    checks++;
    if (err_cnt != e0 + 4) $display("FAIL timeout_once: got %0d pulses, required %0d", err_cnt - e0, 4);
    else passed++;
    send(8'h1C, 0);
    checks++;
    if (exp_q.size() != 0) $display("FAIL recovery_pending: %0d pulses missing, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      b = (r < 4) ? letters[$urandom_range(0, 25)] : (r == 4) ? digits[$urandom_range(0, 9)]
        : (r == 5) ? 8'hF0 : (r == 6) ? 8'hE0 : others[$urandom_range(0, 9)];
      send(b, 0);
    end
    checks++;
    if ({shift_on, caps_on} !== {m_ls | m_rs, m_caps})
      $display("FAIL random_modifiers: got %b%b, required %b%b", shift_on, caps_on, m_ls | m_rs, m_caps);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL random_pending: %0d pulses missing, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [10:0] f;
    send(8'h58, 0);
    send(8'h12, 0);
    f = {1'b1, ~^8'h2D, 8'h2D, 1'b0};
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ascii_key, scancode, valid, shift_on, caps_on, frame_err} !== 20'h0)
      $display("FAIL midframe_reset: got %h, required 0", {ascii_key, scancode, valid, shift_on, caps_on, frame_err});
    else passed++;
    rstn = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    send(8'h1C, 0);
    checks++;
    if (exp_q.size() != 0) $display("FAIL post_reset_pending: %0d pulses missing, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_letter();
    test_shift();
    test_caps();
    test_misc_keys();
    test_extended();
    test_errors();
    test_random();
    test_reset_mid();
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
